// File: rtl/alu_host_sequencer_pkg.sv
// rtl/alu_host_sequencer_pkg.sv - shared state encoding, opcode padding and default sizes for the ALU host sequencer
package alu_host_sequencer_pkg;

  localparam int unsigned DEF_BUS_SIZE       = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;

  // Opcode travels in the low bits of a full bus byte; the top bits are zero.
  localparam int unsigned OP_PAD_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_A   = 3'd1,
    ST_SEND_B   = 3'd2,
    ST_SEND_OP  = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/alu_host_timer.sv
// rtl/alu_host_timer.sv - response-wait counter with clear, enable and terminal-count output
module alu_host_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic i_reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  // Holds 0..TIMEOUT_CYCLES-1; at least one bit so a limit of 1 still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Terminal count fires during the TIMEOUT_CYCLES-th enabled cycle.
  assign tc_o = enable_i && (cnt_q == LAST_CNT);

  // Count enabled cycles, restart whenever cleared, park at the terminal value.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_host_sequencer.sv
// rtl/alu_host_sequencer.sv - sends A, B, opcode to the TX FIFO and collects one result byte from the RX FIFO; ALU_HOST_TIMEOUT_EN adds a response timeout
module alu_host_sequencer
  import alu_host_sequencer_pkg::*;
#(
  parameter int unsigned BUS_SIZE       = DEF_BUS_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [BUS_SIZE-1:0] i_op_a,
  input  logic [BUS_SIZE-1:0] i_op_b,
  input  logic [BUS_SIZE-3:0] i_opcode,
  input  logic                tx_full_signal,
  output logic                wr_signal,
  output logic [BUS_SIZE-1:0] o_tx_data,
  input  logic                rx_empty_signal,
  output logic                rd_signal,
  input  logic [BUS_SIZE-1:0] i_rx_data,
  output logic [BUS_SIZE-1:0] o_result,
  output logic                o_done,
  output logic                o_busy,
  output logic                o_timeout,
  output logic [2:0]          o_state
);

  state_e                state_q;
  logic [BUS_SIZE-1:0]   a_q;
  logic [BUS_SIZE-1:0]   b_q;
  logic [BUS_SIZE-3:0]   op_q;
  logic [BUS_SIZE-1:0]   tx_data_q;
  logic [BUS_SIZE-1:0]   result_q;
  logic                  wr_q;
  logic                  rd_q;
  logic                  done_q;

`ifdef ALU_HOST_TIMEOUT_EN
  logic timeout_q;
  logic timer_tc;

  alu_host_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .i_reset  (i_reset),
    .clear_i  (state_q != ST_WAIT_RES),
    .enable_i (state_q == ST_WAIT_RES),
    .tc_o     (timer_tc)
  );

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign wr_signal = wr_q;
  assign rd_signal = rd_q;
  assign o_tx_data = tx_data_q;
  assign o_result  = result_q;
  assign o_done    = done_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_state   = state_q;

  // Frame sequencer: strobes are registered and default low, so each byte is written at most once.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
      result_q  <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALU_HOST_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            a_q     <= i_op_a;
            b_q     <= i_op_b;
            op_q    <= i_opcode;
            state_q <= ST_SEND_A;
`ifdef ALU_HOST_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        ST_SEND_A: begin
          if (!tx_full_signal) begin
            wr_q      <= 1'b1;
            tx_data_q <= a_q;
            state_q   <= ST_SEND_B;
          end
        end
        ST_SEND_B: begin
          if (!tx_full_signal) begin
            wr_q      <= 1'b1;
            tx_data_q <= b_q;
            state_q   <= ST_SEND_OP;
          end
        end
        ST_SEND_OP: begin
          if (!tx_full_signal) begin
            wr_q      <= 1'b1;
            tx_data_q <= {{OP_PAD_W{1'b0}}, op_q};
            state_q   <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          // A byte that is ready wins over a timeout expiring in the same cycle.
          if (!rx_empty_signal) begin
            rd_q     <= 1'b1;
            result_q <= i_rx_data;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
`ifdef ALU_HOST_TIMEOUT_EN
          else if (timer_tc) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
`endif
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_host_sequencer.sv
// tb/tb_alu_host_sequencer.sv - table-driven and directed checks for alu_host_sequencer
module tb_alu_host_sequencer;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_op_a;
  logic [7:0] i_op_b;
  logic [5:0] i_opcode;
  logic       tx_full_signal;
  logic       wr_signal;
  logic [7:0] o_tx_data;
  logic       rx_empty_signal;
  logic       rd_signal;
  logic [7:0] i_rx_data;
  logic [7:0] o_result;
  logic       o_done;
  logic       o_busy;
  logic       o_timeout;
  logic [2:0] o_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] wr_log[$];
  int rd_cnt   = 0;
  int both_cnt = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] rx;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] w2;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  alu_host_sequencer #(
    .BUS_SIZE(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk             (clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_op_a          (i_op_a),
    .i_op_b          (i_op_b),
    .i_opcode        (i_opcode),
    .tx_full_signal  (tx_full_signal),
    .wr_signal       (wr_signal),
    .o_tx_data       (o_tx_data),
    .rx_empty_signal (rx_empty_signal),
    .rd_signal       (rd_signal),
    .i_rx_data       (i_rx_data),
    .o_result        (o_result),
    .o_done          (o_done),
    .o_busy          (o_busy),
    .o_timeout       (o_timeout),
    .o_state         (o_state)
  );

  // FIFO-side view: what the FIFOs would see on each rising edge.
  always @(posedge clk) begin
    if (wr_signal) wr_log.push_back(o_tx_data);
    if (rd_signal) rd_cnt++;
    if (wr_signal && rd_signal) both_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] wr_at(input int k);
    if (k < wr_log.size()) return wr_log[k];
    return 8'hxx;
  endfunction

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    i_op_a   = a;
    i_op_b   = b;
    i_opcode = op;
    i_start  = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
  endtask

  task automatic wait_done(input string name, inout int n, input int limit);
    while (!o_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!o_done) begin
      checks++;
      errors++;
      $display("FAIL %s o_done absent after %0d cycles", name, limit);
    end
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int limit);
    int k = 0;
    while (o_state != s && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (o_state != s) begin
      checks++;
      errors++;
      $display("FAIL %s state=%0d required=%0d", name, o_state, s);
    end
  endtask

  initial begin
    int n;
    int held_ok;
    int n_at_rst;
    int op_seen;

    vecs[0] = '{a:8'h05, b:8'h03, op:6'h20, rx:8'h08, w0:8'h05, w1:8'h03, w2:8'h20, res:8'h08};
    vecs[1] = '{a:8'hFF, b:8'h00, op:6'h3F, rx:8'hAA, w0:8'hFF, w1:8'h00, w2:8'h3F, res:8'hAA};
    vecs[2] = '{a:8'h80, b:8'h7F, op:6'h15, rx:8'h00, w0:8'h80, w1:8'h7F, w2:8'h15, res:8'h00};
    vecs[3] = '{a:8'hA5, b:8'h5A, op:6'h2A, rx:8'hC3, w0:8'hA5, w1:8'h5A, w2:8'h2A, res:8'hC3};

    i_reset         = 1'b0;
    i_start         = 1'b0;
    i_op_a          = 8'h00;
    i_op_b          = 8'h00;
    i_opcode        = 6'h00;
    tx_full_signal  = 1'b0;
    rx_empty_signal = 1'b1;
    i_rx_data       = 8'h00;
    #1;
    chk("rst_state", o_state, 0);
    chk("rst_wr", wr_signal, 0);
    chk("rst_rd", rd_signal, 0);
    chk("rst_done", o_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_result", o_result, 0);
    chk("rst_txdata", o_tx_data, 0);
    repeat (2) @(negedge clk);
    i_reset = 1'b1;

    // Result byte available while idle must stay in the RX FIFO.
    rx_empty_signal = 1'b0;
    i_rx_data       = 8'h99;
    rd_cnt          = 0;
    repeat (5) @(negedge clk);
    chk("idle_no_rd", rd_cnt, 0);
    chk("idle_state", o_state, 0);

    // Table: free FIFOs, 6-cycle latency counted from the start cycle to the done cycle inclusive.
    for (int i = 0; i < 4; i++) begin
      wr_log.delete();
      rd_cnt          = 0;
      tx_full_signal  = 1'b0;
      rx_empty_signal = 1'b0;
      i_rx_data       = vecs[i].rx;
      pulse_start(vecs[i].a, vecs[i].b, vecs[i].op);
      chk($sformatf("v%0d_busy", i), o_busy, 1);
      n = 1;
      wait_done($sformatf("v%0d_done", i), n, 50);
      chk($sformatf("v%0d_latency", i), n + 1, 6);
      chk($sformatf("v%0d_done_state", i), o_state, 5);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), o_done, 0);
      chk($sformatf("v%0d_idle", i), o_state, 0);
      chk($sformatf("v%0d_idle_busy", i), o_busy, 0);
      chk($sformatf("v%0d_nwr", i), wr_log.size(), 3);
      chk($sformatf("v%0d_w0", i), wr_at(0), vecs[i].w0);
      chk($sformatf("v%0d_w1", i), wr_at(1), vecs[i].w1);
      chk($sformatf("v%0d_w2", i), wr_at(2), vecs[i].w2);
      chk($sformatf("v%0d_result", i), o_result, vecs[i].res);
      chk($sformatf("v%0d_nrd", i), rd_cnt, 1);
      chk($sformatf("v%0d_timeout", i), o_timeout, 0);
    end

    // TX full for 4 cycles while in SEND_B: hold, no write, B written once afterwards.
    wr_log.delete();
    rd_cnt          = 0;
    rx_empty_signal = 1'b0;
    i_rx_data       = 8'h44;
    pulse_start(8'h11, 8'h22, 6'h33);
    wait_state("txfull_reach_b", 3'd2, 20);
    tx_full_signal = 1'b1;
    held_ok = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_state == 3'd2 && !wr_signal) held_ok++;
    end
    chk("txfull_hold", held_ok, 4);
    chk("txfull_nwr_held", wr_log.size(), 1);
    tx_full_signal = 1'b0;
    n = 0;
    wait_done("txfull_done", n, 20);
    @(negedge clk);
    chk("txfull_nwr", wr_log.size(), 3);
    chk("txfull_w0", wr_at(0), 8'h11);
    chk("txfull_w1", wr_at(1), 8'h22);
    chk("txfull_w2", wr_at(2), 8'h33);
    chk("txfull_result", o_result, 8'h44);

    // RX empty for 10 cycles in WAIT_RES, then 0x7F.
    rd_cnt          = 0;
    rx_empty_signal = 1'b1;
    pulse_start(8'h01, 8'h02, 6'h03);
    wait_state("rxwait_reach", 3'd4, 20);
    held_ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_state == 3'd4 && !rd_signal) held_ok++;
    end
    chk("rxwait_hold", held_ok, 10);
    i_rx_data       = 8'h7F;
    rx_empty_signal = 1'b0;
    n = 0;
    wait_done("rxwait_done", n, 20);
    @(negedge clk);
    chk("rxwait_result", o_result, 8'h7F);
    chk("rxwait_nrd", rd_cnt, 1);

    // Response never arrives.
    rd_cnt          = 0;
    rx_empty_signal = 1'b1;
    pulse_start(8'h0A, 8'h0B, 6'h0C);
    wait_state("norx_reach", 3'd4, 20);
`ifdef ALU_HOST_TIMEOUT_EN
    n = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_state != 3'd4) break;
      n++;
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_state", o_state, 5);
    chk("tmo_done", o_done, 1);
    chk("tmo_flag", o_timeout, 1);
    chk("tmo_result", o_result, 8'h7F);
    chk("tmo_nrd", rd_cnt, 0);
    @(negedge clk);
    chk("tmo_sticky", o_timeout, 1);
    i_rx_data       = 8'h3C;
    rx_empty_signal = 1'b0;
    pulse_start(8'h0A, 8'h0B, 6'h0C);
    chk("tmo_cleared", o_timeout, 0);
    n = 1;
    wait_done("tmo_next_done", n, 20);
    @(negedge clk);
`else
    repeat (40) @(negedge clk);
    chk("norx_state", o_state, 4);
    chk("norx_timeout", o_timeout, 0);
    chk("norx_nrd", rd_cnt, 0);
    i_rx_data       = 8'h3C;
    rx_empty_signal = 1'b0;
    n = 0;
    wait_done("norx_done", n, 20);
    @(negedge clk);
`endif
    chk("norx_result", o_result, 8'h3C);

    // i_start while busy is ignored: exactly one frame.
    wr_log.delete();
    rd_cnt          = 0;
    rx_empty_signal = 1'b0;
    i_rx_data       = 8'h5E;
    pulse_start(8'hC1, 8'hC2, 6'h13);
    pulse_start(8'hEE, 8'hEE, 6'h2E);
    @(negedge clk);
    pulse_start(8'hDD, 8'hDD, 6'h1D);
    n = 0;
    wait_done("busy_done", n, 20);
    repeat (8) @(negedge clk);
    chk("busy_nwr", wr_log.size(), 3);
    chk("busy_w0", wr_at(0), 8'hC1);
    chk("busy_w1", wr_at(1), 8'hC2);
    chk("busy_w2", wr_at(2), 8'h13);
    chk("busy_nrd", rd_cnt, 1);
    chk("busy_idle", o_state, 0);

    // Asynchronous reset in SEND_OP abandons the frame.
    wr_log.delete();
    pulse_start(8'h6A, 8'h6B, 6'h2C);
    wait_state("arst_reach_op", 3'd3, 20);
    #2;
    i_reset = 1'b0;
    n_at_rst = wr_log.size();
    #1;
    chk("arst_state", o_state, 0);
    chk("arst_wr", wr_signal, 0);
    chk("arst_rd", rd_signal, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_result", o_result, 0);
    chk("arst_txdata", o_tx_data, 0);
    chk("arst_done", o_done, 0);
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_no_more_wr", wr_log.size(), n_at_rst);
    op_seen = 0;
    foreach (wr_log[k]) if (wr_log[k] == 8'h2C) op_seen++;
    chk("arst_no_op", op_seen, 0);
    chk("arst_idle", o_state, 0);

    chk("wr_rd_overlap", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_host_sequencer.md
ALU_HOST_SEQUENCER -- requirements
Module: alu_host_sequencer

Interface
REQ-001 SHALL have parameter BUS_SIZE, default 8, data byte width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, response-wait limit (used only with ALU_HOST_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports i_start input 1 (request pulse), i_op_a input BUS_SIZE, i_op_b input BUS_SIZE, i_opcode input BUS_SIZE-2.
REQ-006 SHALL have ports tx_full_signal input 1, wr_signal output 1, o_tx_data output BUS_SIZE (TX FIFO write side).
REQ-007 SHALL have ports rx_empty_signal input 1, rd_signal output 1, i_rx_data input BUS_SIZE (RX FIFO read side, head-of-FIFO data valid while not empty).
REQ-008 SHALL have ports o_result output BUS_SIZE, o_done output 1, o_busy output 1, o_timeout output 1, o_state output 3.

Function
REQ-009 SHALL implement states IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES, DONE.
REQ-010 IDLE: on i_start=1, SHALL latch i_op_a, i_op_b, i_opcode and go to SEND_A next cycle; i_start ignored in every other state.
REQ-011 SEND_A/SEND_B/SEND_OP: when tx_full_signal=0, SHALL assert wr_signal for exactly that one cycle with o_tx_data = A, B, or {2'b00, opcode} respectively, then advance; when tx_full_signal=1, SHALL hold state with wr_signal=0.
REQ-012 Bytes SHALL be sent strictly in order A, B, OP; at most one wr_signal pulse per byte, never two consecutive cycles writing the same byte.
REQ-013 WAIT_RES: when rx_empty_signal=0, SHALL assert rd_signal for one cycle, capture i_rx_data into o_result in that same edge, and go to DONE.
REQ-014 DONE: SHALL assert o_done for exactly one cycle, then return to IDLE; o_result SHALL hold until the next capture.
REQ-015 o_busy SHALL be 1 in every state except IDLE.
REQ-016 wr_signal and rd_signal SHALL be registered and never asserted simultaneously.
REQ-017 o_state SHALL encode IDLE=0, SEND_A=1, SEND_B=2, SEND_OP=3, WAIT_RES=4, DONE=5.
REQ-018 Minimum latency i_start to o_done SHALL be 6 cycles with FIFOs never full/empty.
REQ-019 Result bytes arriving while not in WAIT_RES SHALL be left in the RX FIFO (rd_signal=0).

Reset
REQ-020 i_reset=0 SHALL immediately force state IDLE, wr_signal=0, rd_signal=0, o_done=0, o_busy=0, o_timeout=0, o_result=0, o_tx_data=0, latched operands=0.
REQ-021 Reset mid-transaction SHALL abandon the frame; no further writes for it after reset release.

Configuration
REQ-022 With ALU_HOST_TIMEOUT_EN defined, a counter SHALL run in WAIT_RES; on reaching TIMEOUT_CYCLES with rx_empty_signal still 1, SHALL set o_timeout=1 (sticky until next i_start accepted), leave o_result unchanged, and go to DONE.
REQ-023 Without ALU_HOST_TIMEOUT_EN, WAIT_RES SHALL wait indefinitely and o_timeout SHALL be tied 0.

Structure
REQ-024 Shared package SHALL hold state encoding constants, OPCODE padding width (2), and default BUS_SIZE/TIMEOUT_CYCLES.
REQ-025 Timeout counter SHALL be sub-module alu_host_timer (clear, enable, terminal-count output), instantiated only under ALU_HOST_TIMEOUT_EN.

Verification
REQ-026 A=0x05, B=0x03, op=0x20, FIFOs free, RX returns 0x08 -> wr pulses carry 0x05, 0x03, 0x20 in order; o_result=0x08; o_done 1 cycle; 6-cycle latency.
REQ-027 tx_full_signal=1 for 4 cycles during SEND_B -> state holds, no wr pulse, B written once after release.
REQ-028 rx_empty_signal=1 for 10 cycles in WAIT_RES then 0x7F -> single rd pulse, o_result=0x7F.
REQ-029 i_reset=0 asserted in SEND_OP -> outputs zero asynchronously, state IDLE, no OP byte written after release.
REQ-030 ALU_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=16, RX never ready -> o_timeout=1 after 16 cycles in WAIT_RES, o_done pulses, o_result unchanged, no rd pulse.
REQ-031 i_start pulsed while busy -> ignored; only one frame (3 writes) observed.
